operand_issue: RTL and testbench
================================

# operand_issue

Operand-read and issue stage between instruction decode and execute in the 64-bit in-order RISC-V core. Drives the register file read ports and forwards same-cycle writeback data. A 32-entry scoreboard stalls RAW/WAW hazards on in-flight destinations. Results are held in a valid/ready output register feeding execute.

## Interface
- CTRL_W, 16, width of opaque execute control bundle
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- dec_valid_i / dec_ready_o  in/out  1  decode handshake
- dec_rs1_addr_i, dec_rs2_addr_i  in  5  source registers
- dec_rs1_used_i, dec_rs2_used_i  in  1  source actually read
- dec_rd_addr_i  in  5  destination; dec_rd_wr_i  in  1  writes rd
- dec_is_load_i  in  1  load op; dec_ctrl_i  in  CTRL_W  control bundle
- dec_pc_i, dec_imm_i  in  64  pc, sign-extended immediate
- rf_rs1_addr_o, rf_rs2_addr_o  out  5  regfile read addresses (= dec_rs*_addr_i)
- rf_rs1_data_i, rf_rs2_data_i  in  64  combinational regfile read data
- wb_wr_en_i  in  1, wb_rd_addr_i  in  5, wb_rd_data_i  in  64  writeback port (same signals as regfile write port)
- flush_i  in  1  kill instruction held in output register and block accept
- ex_valid_o / ex_ready_i  out/in  1  execute handshake
- ex_rs1_data_o, ex_rs2_data_o, ex_pc_o, ex_imm_o  out  64
- ex_rd_addr_o  out  5, ex_rd_wr_o  out  1, ex_is_load_o  out  1, ex_ctrl_o  out  CTRL_W
- stall_cnt_o  out  32  hazard-stall cycle counter

## Operation
- wb_clr = wb_wr_en_i & wb_rd_addr_i != 0; pend_eff = pending with bit wb_rd_addr_i cleared when wb_clr.
- hazard = (rs1_used & rs1 != 0 & pend_eff[rs1]) | (same for rs2) | (rd_wr & rd != 0 & pend_eff[rd]).
- dec_ready_o = (~ex_valid_o | ex_ready_i) & ~hazard & ~flush_i (combinational).
- Operand select per source: addr 0 -> 0; else wb_clr & wb_rd_addr_i == addr -> wb_rd_data_i; else rf data.
- Accept (dec_valid_i & dec_ready_o): load all ex_* fields, ex_valid_o <= 1; if rd_wr & rd != 0 set pending[rd].
- ex_valid_o & ex_ready_i & no accept: ex_valid_o <= 0. ex_ready_i low: all ex_* held stable.
- Pending bit cleared on wb_clr for wb_rd_addr_i. Set and clear same register same cycle: set wins.
- flush_i: ex_valid_o <= 0; if ex_valid_o & ex_rd_wr_o & ex_rd_addr_o != 0 clear pending[ex_rd_addr_o]; wb clear of another bit still applies. Flush does not affect instructions past execute handoff; those always write back.
- Writes to x0 never set pending; x0 never hazards.
- stall_cnt_o increments when dec_valid_i & hazard & ~flush_i; saturates at 0xFFFF_FFFF.

## Timing
- Reset: ex_valid_o 0, all ex_* data/ctrl 0, pending all 0, stall_cnt_o 0; dec_ready_o 1 after reset when flush_i low.
- Latency: accept at edge N -> ex_valid_o high after N. One issue per cycle maximum.
- No execute-stage forwarding: dependent op stalls until its producer is on the wb port, then issues that cycle with forwarded data.
- Reset mid-stall or mid-flush: all state returns to reset values immediately.

## Test plan
- Reset, write x5=0x1234 via wb, later issue add rs1=x5 -> ex_rs1_data_o=0x1234, ex_valid_o 1 cycle after accept.
- Issue ld x7; next op reads x7 -> dec_ready_o 0, stall_cnt_o counts; wb x7=0xDEAD_BEEF -> issues same cycle, ex_rs1_data_o=0xDEAD_BEEF, pending[7]=0.
- ex_ready_i low 3 cycles with ex_valid_o=1 -> ex_* stable, dec_ready_o 0; release -> next op issues.
- Issue op writing x9, then flush_i -> ex_valid_o 0, pending[9]=0, independent x9 reader issues without stall.
- Source x0 with wb to x0 of 0xFF -> operand 0, no pending; rd=x0 writer never stalls.
- wb clears x3 same cycle new op with rd=x3 accepted -> pending[3]=1 after edge.

Source files
------------

// File: rtl/operand_issue.sv
// operand_issue: operand-read / issue stage between decode and execute.
//   - Drives regfile read addresses straight from decode and picks each operand
//     from x0 (zero), the same-cycle writeback port, or regfile data.
//   - A 32-bit pending scoreboard tracks in-flight destinations; RAW and WAW
//     hazards hold decode until the producer shows up on the writeback port.
//   - One valid/ready output register feeds execute.
// Ports:
//   clk, reset (async, active-high)
//   dec_*_i / dec_ready_o : decode handshake and instruction fields
//   rf_rs*_addr_o / rf_rs*_data_i : combinational regfile read ports
//   wb_*_i   : writeback port (same signals as the regfile write port)
//   flush_i  : kill the held instruction and block accept
//   ex_*_o / ex_ready_i : execute handshake and registered fields
//   stall_cnt_o : saturating count of hazard-stall cycles
module operand_issue #(
    parameter int CTRL_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dec_valid_i,
    output logic              dec_ready_o,
    input  logic [4:0]        dec_rs1_addr_i,
    input  logic [4:0]        dec_rs2_addr_i,
    input  logic              dec_rs1_used_i,
    input  logic              dec_rs2_used_i,
    input  logic [4:0]        dec_rd_addr_i,
    input  logic              dec_rd_wr_i,
    input  logic              dec_is_load_i,
    input  logic [CTRL_W-1:0] dec_ctrl_i,
    input  logic [63:0]       dec_pc_i,
    input  logic [63:0]       dec_imm_i,
    output logic [4:0]        rf_rs1_addr_o,
    output logic [4:0]        rf_rs2_addr_o,
    input  logic [63:0]       rf_rs1_data_i,
    input  logic [63:0]       rf_rs2_data_i,
    input  logic              wb_wr_en_i,
    input  logic [4:0]        wb_rd_addr_i,
    input  logic [63:0]       wb_rd_data_i,
    input  logic              flush_i,
    output logic              ex_valid_o,
    input  logic              ex_ready_i,
    output logic [63:0]       ex_rs1_data_o,
    output logic [63:0]       ex_rs2_data_o,
    output logic [63:0]       ex_pc_o,
    output logic [63:0]       ex_imm_o,
    output logic [4:0]        ex_rd_addr_o,
    output logic              ex_rd_wr_o,
    output logic              ex_is_load_o,
    output logic [CTRL_W-1:0] ex_ctrl_o,
    output logic [31:0]       stall_cnt_o
);

    logic [31:0]       pend_q, pend_d, pend_eff;
    logic              wb_clr, hazard, accept;
    logic [63:0]       op1, op2;
    logic              ex_valid_q, ex_valid_d;
    logic [63:0]       ex_rs1_q, ex_rs2_q, ex_pc_q, ex_imm_q;
    logic [4:0]        ex_rd_q;
    logic              ex_rd_wr_q, ex_ld_q;
    logic [CTRL_W-1:0] ex_ctrl_q;
    logic [31:0]       stall_q;

    // x0 reads as zero; a same-cycle writeback beats the stale regfile value.
    function automatic logic [63:0] sel_op(input logic [4:0] a, input logic [63:0] rfd,
                                           input logic clr, input logic [4:0] wa,
                                           input logic [63:0] wd);
        if (a == 5'd0)             return 64'd0;
        else if (clr && wa == a)   return wd;
        else                       return rfd;
    endfunction

    assign wb_clr = wb_wr_en_i && (wb_rd_addr_i != 5'd0);

    // Scoreboard as seen this cycle: a producer on the wb port is already done.
    always_comb begin
        pend_eff = pend_q;
        if (wb_clr) pend_eff[wb_rd_addr_i] = 1'b0;
    end

    assign hazard = (dec_rs1_used_i && dec_rs1_addr_i != 5'd0 && pend_eff[dec_rs1_addr_i])
                  | (dec_rs2_used_i && dec_rs2_addr_i != 5'd0 && pend_eff[dec_rs2_addr_i])
                  | (dec_rd_wr_i    && dec_rd_addr_i  != 5'd0 && pend_eff[dec_rd_addr_i]);

    assign dec_ready_o = (~ex_valid_q | ex_ready_i) & ~hazard & ~flush_i;
    assign accept      = dec_valid_i & dec_ready_o;

    assign rf_rs1_addr_o = dec_rs1_addr_i;
    assign rf_rs2_addr_o = dec_rs2_addr_i;
    assign op1 = sel_op(dec_rs1_addr_i, rf_rs1_data_i, wb_clr, wb_rd_addr_i, wb_rd_data_i);
    assign op2 = sel_op(dec_rs2_addr_i, rf_rs2_data_i, wb_clr, wb_rd_addr_i, wb_rd_data_i);

    // Set applies last so a new producer wins over a same-cycle wb clear.
    // A flushed instruction will never write back, so its bit is released here.
    always_comb begin
        pend_d = pend_eff;
        if (flush_i && ex_valid_q && ex_rd_wr_q && ex_rd_q != 5'd0)
            pend_d[ex_rd_q] = 1'b0;
        if (accept && dec_rd_wr_i && dec_rd_addr_i != 5'd0)
            pend_d[dec_rd_addr_i] = 1'b1;
    end

    always_comb begin
        ex_valid_d = ex_valid_q;
        if (flush_i)         ex_valid_d = 1'b0;
        else if (accept)     ex_valid_d = 1'b1;
        else if (ex_ready_i) ex_valid_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q     <= '0;
            ex_valid_q <= 1'b0;
            ex_rs1_q   <= '0;
            ex_rs2_q   <= '0;
            ex_pc_q    <= '0;
            ex_imm_q   <= '0;
            ex_rd_q    <= '0;
            ex_rd_wr_q <= 1'b0;
            ex_ld_q    <= 1'b0;
            ex_ctrl_q  <= '0;
            stall_q    <= '0;
        end else begin
            pend_q     <= pend_d;
            ex_valid_q <= ex_valid_d;
            if (accept) begin
                ex_rs1_q   <= op1;
                ex_rs2_q   <= op2;
                ex_pc_q    <= dec_pc_i;
                ex_imm_q   <= dec_imm_i;
                ex_rd_q    <= dec_rd_addr_i;
                ex_rd_wr_q <= dec_rd_wr_i;
                ex_ld_q    <= dec_is_load_i;
                ex_ctrl_q  <= dec_ctrl_i;
            end
            if (dec_valid_i && hazard && !flush_i && stall_q != 32'hFFFF_FFFF)
                stall_q <= stall_q + 32'd1;
        end
    end

    assign ex_valid_o    = ex_valid_q;
    assign ex_rs1_data_o = ex_rs1_q;
    assign ex_rs2_data_o = ex_rs2_q;
    assign ex_pc_o       = ex_pc_q;
    assign ex_imm_o      = ex_imm_q;
    assign ex_rd_addr_o  = ex_rd_q;
    assign ex_rd_wr_o    = ex_rd_wr_q;
    assign ex_is_load_o  = ex_ld_q;
    assign ex_ctrl_o     = ex_ctrl_q;
    assign stall_cnt_o   = stall_q;

endmodule

// File: tb/tb_operand_issue.sv
module tb_operand_issue;
    localparam int CTRL_W = 16;

    logic clk = 1'b0, reset;
    logic dec_valid_i, dec_ready_o;
    logic [4:0] dec_rs1_addr_i, dec_rs2_addr_i, dec_rd_addr_i;
    logic dec_rs1_used_i, dec_rs2_used_i, dec_rd_wr_i, dec_is_load_i;
    logic [CTRL_W-1:0] dec_ctrl_i;
    logic [63:0] dec_pc_i, dec_imm_i;
    logic [4:0] rf_rs1_addr_o, rf_rs2_addr_o;
    logic [63:0] rf_rs1_data_i, rf_rs2_data_i;
    logic wb_wr_en_i;
    logic [4:0] wb_rd_addr_i;
    logic [63:0] wb_rd_data_i;
    logic flush_i, ex_valid_o, ex_ready_i;
    logic [63:0] ex_rs1_data_o, ex_rs2_data_o, ex_pc_o, ex_imm_o;
    logic [4:0] ex_rd_addr_o;
    logic ex_rd_wr_o, ex_is_load_o;
    logic [CTRL_W-1:0] ex_ctrl_o;
    logic [31:0] stall_cnt_o;

    operand_issue #(.CTRL_W(CTRL_W)) dut (
        .clk(clk), .reset(reset),
        .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
        .dec_rs1_addr_i(dec_rs1_addr_i), .dec_rs2_addr_i(dec_rs2_addr_i),
        .dec_rs1_used_i(dec_rs1_used_i), .dec_rs2_used_i(dec_rs2_used_i),
        .dec_rd_addr_i(dec_rd_addr_i), .dec_rd_wr_i(dec_rd_wr_i),
        .dec_is_load_i(dec_is_load_i), .dec_ctrl_i(dec_ctrl_i),
        .dec_pc_i(dec_pc_i), .dec_imm_i(dec_imm_i),
        .rf_rs1_addr_o(rf_rs1_addr_o), .rf_rs2_addr_o(rf_rs2_addr_o),
        .rf_rs1_data_i(rf_rs1_data_i), .rf_rs2_data_i(rf_rs2_data_i),
        .wb_wr_en_i(wb_wr_en_i), .wb_rd_addr_i(wb_rd_addr_i), .wb_rd_data_i(wb_rd_data_i),
        .flush_i(flush_i), .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
        .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o),
        .ex_pc_o(ex_pc_o), .ex_imm_o(ex_imm_o), .ex_rd_addr_o(ex_rd_addr_o),
        .ex_rd_wr_o(ex_rd_wr_o), .ex_is_load_o(ex_is_load_o), .ex_ctrl_o(ex_ctrl_o),
        .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    // Regfile model; x0 holds junk so the stage must force zero itself.
    logic [63:0] rf [32];
    assign rf_rs1_data_i = rf[rf_rs1_addr_o];
    assign rf_rs2_data_i = rf[rf_rs2_addr_o];

    typedef struct {
        logic [63:0] rs1, rs2, pc, imm;
        logic [4:0]  rd;
        logic        wr, ld;
        logic [CTRL_W-1:0] ctrl;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic [4:0] rs1, rs2; logic u1, u2;
        logic [4:0] rd; logic wr, ld;
        logic wb_en; logic [4:0] wb_a; logic [63:0] wb_d;
        logic exp_ready;
    } vec_t;
    vec_t tbl[11];

    int total = 0, bad = 0;
    int exp_stall = 0;
    logic s_ready;
    logic [63:0] pc_ctr = 64'h8000_0000;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] m_op(input logic [4:0] a);
        if (a == 5'd0) return 64'd0;
        if (wb_wr_en_i && wb_rd_addr_i == a) return wb_rd_data_i;
        return rf[a];
    endfunction

    task automatic idle();
        dec_valid_i = 0; dec_rs1_addr_i = 0; dec_rs2_addr_i = 0;
        dec_rs1_used_i = 0; dec_rs2_used_i = 0; dec_rd_addr_i = 0;
        dec_rd_wr_i = 0; dec_is_load_i = 0; dec_ctrl_i = 0;
        dec_pc_i = 0; dec_imm_i = 0;
        wb_wr_en_i = 0; wb_rd_addr_i = 0; wb_rd_data_i = 0; flush_i = 0;
    endtask

    task automatic set_op(input logic [4:0] r1, input logic [4:0] r2, input logic u1,
                          input logic u2, input logic [4:0] rd, input logic wr, input logic ld);
        dec_valid_i = 1; dec_rs1_addr_i = r1; dec_rs2_addr_i = r2;
        dec_rs1_used_i = u1; dec_rs2_used_i = u2; dec_rd_addr_i = rd;
        dec_rd_wr_i = wr; dec_is_load_i = ld;
        pc_ctr += 4;
        dec_pc_i = pc_ctr; dec_imm_i = ~pc_ctr;
        dec_ctrl_i = pc_ctr[15:0] ^ 16'h5A5A;
    endtask

    task automatic set_wb(input logic en, input logic [4:0] a, input logic [63:0] d);
        wb_wr_en_i = en; wb_rd_addr_i = a; wb_rd_data_i = d;
    endtask

    // One cycle: inputs were driven at the negedge; sample mid-cycle, run
    // the scoreboard, cross the posedge, update the regfile model.
    task automatic tick();
        exp_t e;
        #2;
        s_ready = dec_ready_o;
        if (ex_valid_o && (flush_i || ex_ready_i)) begin
            if (sbq.size() == 0) begin
                chk("sb_underflow", 64'd1, 64'd0);
            end else begin
                e = sbq.pop_front();
                if (!flush_i) begin
                    chk("sb_rs1", ex_rs1_data_o, e.rs1);
                    chk("sb_rs2", ex_rs2_data_o, e.rs2);
                    chk("sb_pc",  ex_pc_o, e.pc);
                    chk("sb_imm", ex_imm_o, e.imm);
                    chk("sb_meta", {41'd0, ex_ctrl_o, ex_rd_addr_o, ex_rd_wr_o, ex_is_load_o},
                                   {41'd0, e.ctrl, e.rd, e.wr, e.ld});
                end
            end
        end
        if (dec_valid_i && dec_ready_o) begin
            e.rs1 = m_op(dec_rs1_addr_i); e.rs2 = m_op(dec_rs2_addr_i);
            e.pc = dec_pc_i; e.imm = dec_imm_i; e.rd = dec_rd_addr_i;
            e.wr = dec_rd_wr_i; e.ld = dec_is_load_i; e.ctrl = dec_ctrl_i;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        if (wb_wr_en_i && wb_rd_addr_i != 0) rf[wb_rd_addr_i] = wb_rd_data_i;
        @(negedge clk);
    endtask

    initial begin
        logic [63:0] xpc;
        for (int i = 0; i < 32; i++) rf[i] = 64'hA5A5_0000_0000_0000 | 64'(i * 32'h111);
        rf[0] = 64'hBAD;
        idle(); ex_ready_i = 1; reset = 1;
        repeat (2) @(negedge clk);
        chk("rst_ex_valid", {63'd0, ex_valid_o}, 64'd0);
        chk("rst_ex_rs1", ex_rs1_data_o, 64'd0);
        chk("rst_ex_pc", ex_pc_o, 64'd0);
        chk("rst_ex_meta", {ex_ctrl_o, ex_rd_addr_o, ex_rd_wr_o, ex_is_load_o}, 64'd0);
        chk("rst_stall", {32'd0, stall_cnt_o}, 64'd0);
        chk("rst_ready", {63'd0, dec_ready_o}, 64'd1);
        reset = 0;
        @(negedge clk);

        // Table: rs1 rs2 u1 u2 rd wr ld wb_en wb_a wb_d ready
        tbl[0]  = '{5'd1,  5'd2,  1,1, 5'd0,  1,0, 0,5'd0, 64'd0, 1};
        tbl[1]  = '{5'd0,  5'd31, 1,1, 5'd0,  0,0, 0,5'd0, 64'd0, 1};
        tbl[2]  = '{5'd4,  5'd4,  1,1, 5'd0,  0,0, 1,5'd4, 64'hAAAA, 1};
        tbl[3]  = '{5'd0,  5'd0,  1,1, 5'd0,  1,0, 1,5'd0, 64'hFF, 1};
        tbl[4]  = '{5'd5,  5'd6,  1,0, 5'd11, 0,0, 0,5'd0, 64'd0, 1};
        tbl[5]  = '{5'd11, 5'd13, 1,1, 5'd12, 1,0, 0,5'd0, 64'd0, 1};
        tbl[6]  = '{5'd12, 5'd1,  1,1, 5'd0,  0,0, 0,5'd0, 64'd0, 0};
        tbl[7]  = '{5'd1,  5'd12, 0,1, 5'd12, 1,0, 1,5'd12, 64'hC0DE, 1};
        tbl[8]  = '{5'd12, 5'd12, 0,0, 5'd2,  0,0, 0,5'd0, 64'd0, 1};
        tbl[9]  = '{5'd2,  5'd3,  1,1, 5'd12, 1,0, 0,5'd0, 64'd0, 0};
        tbl[10] = '{5'd0,  5'd0,  0,0, 5'd0,  0,1, 1,5'd12, 64'h77, 1};
        for (int i = 0; i < 11; i++) begin
            set_op(tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2, tbl[i].rd, tbl[i].wr, tbl[i].ld);
            set_wb(tbl[i].wb_en, tbl[i].wb_a, tbl[i].wb_d);
            #1;
            chk($sformatf("tbl%0d_rfaddr", i), {54'd0, rf_rs1_addr_o, rf_rs2_addr_o},
                {54'd0, tbl[i].rs1, tbl[i].rs2});
            tick();
            chk($sformatf("tbl%0d_ready", i), {63'd0, s_ready}, {63'd0, tbl[i].exp_ready});
            if (!tbl[i].exp_ready) exp_stall++;
        end
        idle(); tick();
        chk("tbl_stall", {32'd0, stall_cnt_o}, 64'(exp_stall));

        // wb x5 then a reader sees it through the regfile
        set_wb(1, 5'd5, 64'h1234); tick(); idle(); tick();
        set_op(5'd5, 5'd0, 1, 0, 5'd0, 0, 0); tick();
        chk("x5_ready", {63'd0, s_ready}, 64'd1);
        chk("x5_valid", {63'd0, ex_valid_o}, 64'd1);
        chk("x5_data", ex_rs1_data_o, 64'h1234);

        // load x7, dependent stalls until wb, then issues with forwarded data
        set_op(5'd0, 5'd0, 0, 0, 5'd7, 1, 1); tick();
        chk("ld7_ready", {63'd0, s_ready}, 64'd1);
        set_op(5'd7, 5'd0, 1, 0, 5'd8, 1, 0);
        for (int k = 0; k < 3; k++) begin
            tick(); exp_stall++;
            chk("raw7_stalled", {63'd0, s_ready}, 64'd0);
        end
        chk("raw7_stall_cnt", {32'd0, stall_cnt_o}, 64'(exp_stall));
        set_wb(1, 5'd7, 64'hDEAD_BEEF); tick();
        chk("raw7_issue", {63'd0, s_ready}, 64'd1);
        chk("raw7_fwd", ex_rs1_data_o, 64'hDEAD_BEEF);
        set_wb(1, 5'd8, 64'h88);
        set_op(5'd7, 5'd7, 1, 1, 5'd0, 0, 0); tick();
        chk("x7_cleared", {63'd0, s_ready}, 64'd1);
        idle(); tick();

        // execute backpressure
        set_op(5'd1, 5'd2, 1, 1, 5'd0, 0, 0); xpc = dec_pc_i; tick();
        ex_ready_i = 0;
        set_op(5'd3, 5'd4, 1, 1, 5'd0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_ready", {63'd0, s_ready}, 64'd0);
            chk("bp_valid", {63'd0, ex_valid_o}, 64'd1);
            chk("bp_pc_hold", ex_pc_o, xpc);
        end
        chk("bp_no_stallcnt", {32'd0, stall_cnt_o}, 64'(exp_stall));
        ex_ready_i = 1; tick();
        chk("bp_release", {63'd0, s_ready}, 64'd1);
        idle(); tick();

        // flush releases the killed producer's pending bit
        set_op(5'd0, 5'd0, 0, 0, 5'd9, 1, 0); tick();
        idle(); ex_ready_i = 0; flush_i = 1; tick();
        chk("flush_ready", {63'd0, s_ready}, 64'd0);
        chk("flush_valid", {63'd0, ex_valid_o}, 64'd0);
        flush_i = 0; ex_ready_i = 1;
        set_op(5'd9, 5'd0, 1, 0, 5'd0, 0, 0); tick();
        chk("flush_x9_free", {63'd0, s_ready}, 64'd1);
        chk("flush_stallcnt", {32'd0, stall_cnt_o}, 64'(exp_stall));

        // x0 source and destination
        set_wb(1, 5'd0, 64'hFF);
        set_op(5'd0, 5'd0, 1, 1, 5'd0, 1, 0); tick();
        chk("x0_ready", {63'd0, s_ready}, 64'd1);
        chk("x0_op", ex_rs1_data_o | ex_rs2_data_o, 64'd0);
        set_wb(0, 5'd0, 64'd0);
        set_op(5'd0, 5'd0, 1, 0, 5'd0, 1, 0); tick();
        chk("x0_waw", {63'd0, s_ready}, 64'd1);

        // same-cycle clear and set of x3: set wins
        set_op(5'd0, 5'd0, 0, 0, 5'd3, 1, 0); tick();
        set_wb(1, 5'd3, 64'h3333);
        set_op(5'd0, 5'd0, 0, 0, 5'd3, 1, 0); tick();
        chk("x3_waw_clr", {63'd0, s_ready}, 64'd1);
        set_wb(0, 5'd0, 64'd0);
        set_op(5'd3, 5'd0, 1, 0, 5'd0, 0, 0); tick(); exp_stall++;
        chk("x3_still_pend", {63'd0, s_ready}, 64'd0);
        set_wb(1, 5'd3, 64'h4444); tick();
        chk("x3_issue", {63'd0, s_ready}, 64'd1);
        chk("x3_fwd", ex_rs1_data_o, 64'h4444);
        chk("x3_stallcnt", {32'd0, stall_cnt_o}, 64'(exp_stall));
        idle(); tick(); tick();
        chk("sb_drained", 64'(sbq.size()), 64'd0);

        // asynchronous reset mid-stall
        set_op(5'd0, 5'd0, 0, 0, 5'd20, 1, 0); tick();
        set_op(5'd20, 5'd0, 1, 0, 5'd0, 0, 0); tick();
        chk("r20_stall", {63'd0, s_ready}, 64'd0);
        #3 reset = 1; #1;
        chk("mid_rst_valid", {63'd0, ex_valid_o}, 64'd0);
        chk("mid_rst_stall", {32'd0, stall_cnt_o}, 64'd0);
        chk("mid_rst_pc", ex_pc_o, 64'd0);
        chk("mid_rst_ready", {63'd0, dec_ready_o}, 64'd1);
        sbq.delete();
        dec_valid_i = 0;
        @(negedge clk); reset = 0;
        set_op(5'd20, 5'd0, 1, 0, 5'd0, 0, 0); tick();
        chk("r20_after_rst", {63'd0, s_ready}, 64'd1);
        idle(); tick(); tick();
        chk("sb_final", 64'(sbq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
